// File: rtl/mtf_dictionary.sv
`default_nettype none
// ============================================================================
// Module   : mtf_dictionary
// Purpose  : Move-to-front word dictionary with per-entry byte compare vectors.
//            Optional hit/miss statistics enabled by MTF_DICT_STATS_EN.
// Revision : 1.0
// ============================================================================
module mtf_dictionary #(
   parameter int DEPTH = 16,
   parameter int IDX_W = 4
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [31:0]        i_data,
   output logic               o_cmp_valid,
   output logic [4*DEPTH-1:0] o_cmp_vec,
   output logic [DEPTH-1:0]   o_valid_mask,
   input  logic               i_upd_valid,
   input  logic               i_upd_hit,
   input  logic [IDX_W-1:0]   i_upd_index,
   input  logic               i_flush,
   output logic [15:0]        o_hit_count,
   output logic [15:0]        o_miss_count
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COMPARE = 2'd1,
      ST_HOLD    = 2'd2
   } state_t;

   state_t             r_state;
   logic               r_ready;
   logic               r_cmp_valid;
   logic [4*DEPTH-1:0] r_cmp_vec;
   logic [DEPTH-1:0]   r_mask;
   logic [31:0]        r_search;
   logic [31:0]        r_entry [DEPTH];

   logic [4*DEPTH-1:0] w_cmp;
   logic               w_hit_ok;

   // A hit on an empty slot carries no usable data, so it degrades to a miss.
   assign w_hit_ok = i_upd_hit && r_mask[i_upd_index];

   always_comb begin
      w_cmp = '0;
      for (int e = 0; e < DEPTH; e++) begin
         for (int k = 0; k < 4; k++) begin
            w_cmp[4*e+k] = r_mask[e] && (r_search[8*k +: 8] == r_entry[e][8*k +: 8]);
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= ST_IDLE;
         r_ready     <= 1'b1;
         r_cmp_valid <= 1'b0;
         r_cmp_vec   <= '0;
         r_mask      <= '0;
         r_search    <= '0;
         for (int j = 0; j < DEPTH; j++) r_entry[j] <= '0;
      end else if (i_flush) begin
         r_state     <= ST_IDLE;
         r_ready     <= 1'b1;
         r_cmp_valid <= 1'b0;
         r_cmp_vec   <= '0;
         r_mask      <= '0;
         for (int j = 0; j < DEPTH; j++) r_entry[j] <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_valid) begin
                  r_search <= i_data;
                  r_ready  <= 1'b0;
                  r_state  <= ST_COMPARE;
               end
            end
            ST_COMPARE: begin
               r_cmp_vec   <= w_cmp;
               r_cmp_valid <= 1'b1;
               r_state     <= ST_HOLD;
            end
            ST_HOLD: begin
               if (i_upd_valid) begin
                  if (w_hit_ok) begin
                     for (int j = 1; j < DEPTH; j++) begin
                        if (IDX_W'(j) <= i_upd_index) r_entry[j] <= r_entry[j-1];
                     end
                     r_entry[0] <= r_entry[i_upd_index];
                  end else begin
                     for (int j = 1; j < DEPTH; j++) r_entry[j] <= r_entry[j-1];
                     r_entry[0] <= r_search;
                     r_mask     <= {r_mask[DEPTH-2:0], 1'b1};
                  end
                  r_cmp_valid <= 1'b0;
                  r_ready     <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign o_ready      = r_ready;
   assign o_cmp_valid  = r_cmp_valid;
   assign o_cmp_vec    = r_cmp_vec;
   assign o_valid_mask = r_mask;

`ifdef MTF_DICT_STATS_EN
   logic        w_apply;
   logic [15:0] r_hit_count;
   logic [15:0] r_miss_count;

   assign w_apply = (r_state == ST_HOLD) && i_upd_valid && !i_flush;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_hit_count  <= '0;
         r_miss_count <= '0;
      end else if (w_apply) begin
         if (w_hit_ok) begin
            if (r_hit_count != 16'hFFFF) r_hit_count <= r_hit_count + 16'd1;
         end else begin
            if (r_miss_count != 16'hFFFF) r_miss_count <= r_miss_count + 16'd1;
         end
      end
   end

   assign o_hit_count  = r_hit_count;
   assign o_miss_count = r_miss_count;
`else
   assign o_hit_count  = 16'h0000;
   assign o_miss_count = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: doc/mtf_dictionary.md
Name: mtf_dictionary

Overview:
- Move-to-front (MTF) dictionary for the compressor, directly upstream of the per-entry word_decoder bank.
- Accepts one 32-bit input word, compares it byte-wise against every dictionary entry, and presents one 4-bit compare vector per entry to the decoders.
- Then waits for the match-select stage's decision and updates the dictionary: hit moves the matched entry to position 0; miss inserts the new word at position 0.

Parameters:
- DEPTH, 16, number of dictionary entries (power of 2, ≥2).
- IDX_W, 4, index width; equals log2(DEPTH).

Ports:
- i_clk  input  1  clock, rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_valid  input  1  search word valid.
- o_ready  output  1  block can accept a search word.
- i_data  input  32  word to search; byte k = i_data[8k+7:8k].
- o_cmp_valid  output  1  compare vectors valid; waiting for update.
- o_cmp_vec  output  4*DEPTH  entry e's vector at [4e+3:4e]; bit k=1 when byte k equals entry byte k.
- o_valid_mask  output  DEPTH  bit e=1 when entry e holds data.
- i_upd_valid  input  1  update command valid.
- i_upd_hit  input  1  1=hit (move-to-front), 0=miss (insert).
- i_upd_index  input  IDX_W  matched entry index (used only on hit).
- i_flush  input  1  synchronous dictionary clear.
- o_hit_count  output  16  hit counter (see optional feature).
- o_miss_count  output  16  miss counter (see optional feature).

Behaviour:
- Reset (async): all entries 0, o_valid_mask=0, FSM in IDLE, o_ready=1, o_cmp_valid=0, o_cmp_vec=0, counters 0.
- FSM states: IDLE, COMPARE, HOLD.
- IDLE: o_ready=1. When i_valid&&o_ready at edge N, latch i_data into the search register and go to COMPARE.
- COMPARE: one cycle. Byte-compare the search register against all entries and register the result into o_cmp_vec at edge N+1. Go to HOLD.
- Invalid entries always produce vector 4'b0000.
- HOLD: o_cmp_valid=1 from cycle N+1 onward; o_cmp_vec stays stable. o_ready=0 in COMPARE and HOLD.
- HOLD exit: on i_upd_valid=1 at an edge, apply the update on that edge and return to IDLE. o_cmp_valid=0 and o_ready=1 on the next cycle.
- Hit with index h valid: new[0]=old[h]; new[j]=old[j-1] for 1≤j≤h; entries above h unchanged; valid mask unchanged.
- Hit where index h refers to an invalid entry: treated as a miss.
- Miss: new[0]=search word; new[j]=old[j-1] for all j≥1; old[DEPTH-1] dropped; valid mask shifts left with bit0=1, saturating when all ones.
- Hit at index 0: dictionary unchanged.
- i_upd_valid outside HOLD: ignored, no state change.
- i_flush: highest priority except reset. At the edge it clears the valid mask and entry contents, returns the FSM to IDLE, and clears o_cmp_valid and o_cmp_vec. A pending search is discarded. A simultaneous i_valid is not accepted. Counters are not affected.
- i_valid in COMPARE/HOLD: not accepted; the source holds the word.
- Throughput: one word per 3 cycles minimum (accept, compare, update).
- Async reset asserted mid-operation: immediate return to reset values, no update applied.

Optional Feature:
- Macro: MTF_DICT_STATS_EN.
- Defined: o_hit_count increments on each applied hit update; o_miss_count increments on each applied miss update, including a hit converted to a miss. Both saturate at 16'hFFFF. Cleared only by reset.
- Not defined: no counter logic; o_hit_count and o_miss_count tied to 16'h0000.

Test Plan:
- Reset, then search 32'hAABBCCDD -> o_cmp_valid high one cycle after COMPARE, o_cmp_vec all 0, o_valid_mask=0. Miss update -> entry0=32'hAABBCCDD, mask=16'h0001.
- Insert 32'h11223344, 32'h55667788, 32'h99AABBCC by misses. Search 32'h11220000 -> entry2 vector 4'b1100, others 4'b0000. Hit index 2 -> order: 11223344, 99AABBCC, 55667788.
- 17 miss inserts of 1..17 -> mask=16'hFFFF, entry0=17, entry15=2, word 1 dropped.
- Hit with index 5 while mask=16'h0007 -> behaves as miss; mask becomes 16'h000F.
- i_flush asserted in HOLD -> next cycle mask=0, o_cmp_valid=0, o_ready=1. A following i_upd_valid is ignored.
- With MTF_DICT_STATS_EN: 3 hits and 2 misses -> o_hit_count=3, o_miss_count=2. Without the macro, both read 0.
